// File: rtl/regfile_2r1w_if.sv
// Register-file access bundle: two read ports, one write port and the ready flag.
interface regfile_2r1w_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = 5
);
  logic [AW-1:0]    rdA;
  logic [AW-1:0]    rdB;
  logic [AW-1:0]    wrAddr;
  logic [WIDTH-1:0] wrData;
  logic             wrEn;
  logic [WIDTH-1:0] outA;
  logic [WIDTH-1:0] outB;
  logic             ready;

  modport master (
    output rdA, rdB, wrAddr, wrData, wrEn,
    input  outA, outB, ready
  );

  modport slave (
    input  rdA, rdB, wrAddr, wrData, wrEn,
    output outA, outB, ready
  );
endinterface

// File: rtl/regfile_2r1w.sv
// 2-read/1-write register file, r0 hardwired to zero, with a post-reset clear sweep.
// Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_2r1w #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = 5
) (
  input logic             clk,
  input logic             rst,
  regfile_2r1w_if.slave   bus
);
  localparam logic [AW-1:0] LAST = '1;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state;
  logic [AW-1:0]     ptr;
  logic              ready;
  logic [WIDTH-1:0]  mem [1:2**AW-1];
  logic [WIDTH-1:0]  rd_a;
  logic [WIDTH-1:0]  rd_b;
  logic              wr_ok;

  assign wr_ok = ready && bus.wrEn && (bus.wrAddr != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      ptr   <= AW'(1);
      ready <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          if (ptr == LAST) begin
            state <= RUN;
            ready <= 1'b1;
          end else begin
            ptr <= ptr + AW'(1);
          end
        end
        RUN: ;
        default: state <= CLEAR;
      endcase
    end
  end

  // Storage has no reset of its own; the sweep zeroes it while ready masks the reads.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        if (ptr != '0) mem[ptr] <= '0;
      end else if (wr_ok) begin
        mem[bus.wrAddr] <= bus.wrData;
      end
    end
  end

  always_comb begin
    rd_a = '0;
    rd_b = '0;
    if (bus.rdA != '0) rd_a = mem[bus.rdA];
    if (bus.rdB != '0) rd_b = mem[bus.rdB];
`ifdef REGFILE_BYPASS_EN
    if (wr_ok && (bus.rdA == bus.wrAddr)) rd_a = bus.wrData;
    if (wr_ok && (bus.rdB == bus.wrAddr)) rd_b = bus.wrData;
`endif
  end

  assign bus.outA  = ready ? rd_a : '0;
  assign bus.outB  = ready ? rd_b : '0;
  assign bus.ready = ready;
endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed bench for regfile_2r1w: sweep timing, masking, r0, gating, same-cycle reads, reset.
module tb_regfile_2r1w;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned AW    = 5;

  logic clk;
  logic rst;
  int unsigned n_chk;
  int unsigned n_err;

  regfile_2r1w_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  regfile_2r1w #(.WIDTH(WIDTH), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expects the edge with rst=1 to have just passed and rst now low.
  task automatic sweep(input string tag);
    for (int unsigned i = 1; i < 31; i++) begin
      step();
      check({tag, "_ready_lo"}, {31'd0, bus.ready}, 32'd0);
      check({tag, "_maskA"}, bus.outA, 32'd0);
      check({tag, "_maskB"}, bus.outB, 32'd0);
    end
    step();
    check({tag, "_ready_hi"}, {31'd0, bus.ready}, 32'd1);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst = 1'b1;
    bus.rdA = '0;
    bus.rdB = '0;
    bus.wrAddr = '0;
    bus.wrData = '0;
    bus.wrEn = 1'b0;

    // Holding reset keeps ready low.
    for (int unsigned i = 0; i < 5; i++) begin
      step();
      check("hold_rst_ready", {31'd0, bus.ready}, 32'd0);
      check("hold_rst_outA", bus.outA, 32'd0);
    end
    rst = 1'b0;

    // Write to r7 during the sweep must be dropped.
    bus.wrAddr = 5'd7;
    bus.wrData = 32'h0000_1234;
    bus.wrEn = 1'b1;
    bus.rdA = 5'd7;
    bus.rdB = 5'd17;
    sweep("sweep1");
    bus.wrEn = 1'b0;
    #1;
    check("r7_dropped", bus.outA, 32'd0);
    bus.rdA = 5'd31;
    bus.rdB = 5'd1;
    #1;
    check("r31_zero", bus.outA, 32'd0);
    check("r1_zero", bus.outB, 32'd0);

    // Basic write/read.
    bus.wrAddr = 5'd5;
    bus.wrData = 32'hDEAD_BEEF;
    bus.wrEn = 1'b1;
    step();
    bus.wrEn = 1'b0;
    bus.rdA = 5'd5;
    bus.rdB = 5'd5;
    #1;
    check("r5_A", bus.outA, 32'hDEAD_BEEF);
    check("r5_B", bus.outB, 32'hDEAD_BEEF);
    bus.rdA = 5'd6;
    #1;
    check("r6_zero", bus.outA, 32'd0);
    check("r5_B_hold", bus.outB, 32'hDEAD_BEEF);

    // r0 ignores writes.
    bus.wrAddr = 5'd0;
    bus.wrData = 32'hFFFF_FFFF;
    bus.wrEn = 1'b1;
    step();
    bus.wrEn = 1'b0;
    bus.rdA = 5'd0;
    bus.rdB = 5'd0;
    #1;
    check("r0_A", bus.outA, 32'd0);
    check("r0_B", bus.outB, 32'd0);

    // Same-cycle read of a register being written.
    bus.wrAddr = 5'd9;
    bus.wrData = 32'h11;
    bus.wrEn = 1'b1;
    step();
    bus.wrData = 32'h22;
    bus.rdA = 5'd9;
    bus.rdB = 5'd9;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("r9_same_A", bus.outA, 32'h22);
    check("r9_same_B", bus.outB, 32'h22);
`else
    check("r9_same_A", bus.outA, 32'h11);
    check("r9_same_B", bus.outB, 32'h11);
`endif
    step();
    bus.wrEn = 1'b0;
    #1;
    check("r9_next_A", bus.outA, 32'h22);

    // r0 writes are never forwarded.
    bus.wrAddr = 5'd0;
    bus.wrData = 32'hCAFE;
    bus.wrEn = 1'b1;
    bus.rdA = 5'd0;
    bus.rdB = 5'd0;
    #1;
    check("r0_fwd_A", bus.outA, 32'd0);
    check("r0_fwd_B", bus.outB, 32'd0);
    step();
    bus.wrEn = 1'b0;

    // Reset 10 edges into a sweep restarts it.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int unsigned i = 0; i < 10; i++) step();
    check("mid_sweep_ready", {31'd0, bus.ready}, 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    sweep("sweep2");

    // Reset during RUN clears r3.
    bus.wrAddr = 5'd3;
    bus.wrData = 32'hA5;
    bus.wrEn = 1'b1;
    step();
    bus.wrEn = 1'b0;
    bus.rdA = 5'd3;
    bus.rdB = 5'd9;
    #1;
    check("r3_written", bus.outA, 32'hA5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("run_rst_ready", {31'd0, bus.ready}, 32'd0);
    sweep("sweep3");
    check("r3_cleared", bus.outA, 32'd0);
    check("r9_cleared", bus.outB, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
